cirno9_cpu_top: RTL and testbench

- Top level of the cirno9 RV32I processor.
- Instantiates a single-cycle core `u_cirno9_core` and a unified 64 KiB word-organised SRAM `u_sram32`, which serves both instruction fetch and data access.
- Has no external bus. Program images are preloaded through hierarchical access to the SRAM array before reset is released.

---
 rtl/cirno9_cpu_top.sv | 263 ++++++++++++++++++++++++++
 tb/tb_cirno9_cpu_top.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/cirno9_cpu_top.sv
// cirno9 RV32I single-cycle processor: core, register file and unified 64 KiB SRAM.
// Optional machine-mode CSRs, ECALL and MRET are built when CIRNO9_TRAP_EN is defined.

module cirno9_regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data
);
    logic [31:0] rf_r [0:31];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf_r[i] <= '0;
        end else if (wr_en && wr_addr != 5'd0) begin
            rf_r[wr_addr] <= wr_data;
        end
    end

    assign rs1_data = (rs1_addr == 5'd0) ? 32'd0 : rf_r[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0) ? 32'd0 : rf_r[rs2_addr];
endmodule

module cirno9_sram32 #(
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic [AW-1:0] iaddr,
    output logic [31:0]   idata,
    input  logic [AW-1:0] daddr,
    output logic [31:0]   drdata,
    input  logic [3:0]    dwe,
    input  logic [31:0]   dwdata
);
    // No reset on the array: preloaded images must survive reset.
    logic [31:0] mem_r [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (dwe[b]) mem_r[daddr][b*8 +: 8] <= dwdata[b*8 +: 8];
        end
    end

    assign idata  = mem_r[iaddr];
    assign drdata = mem_r[daddr];
endmodule

module cirno9_core #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] dmem_addr,
    input  logic [31:0] dmem_rdata,
    output logic [3:0]  dmem_we,
    output logic [31:0] dmem_wdata
);
    logic [31:0] pc_r, next_pc, instr, rs1_val, rs2_val, rd_wdata;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic        rd_we, taken;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    function automatic logic [31:0] alu(input logic [2:0] op, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'b000:  alu = alt ? a - b : a + b;
            3'b001:  alu = a << b[4:0];
            3'b010:  alu = {31'd0, $signed(a) < $signed(b)};
            3'b011:  alu = {31'd0, a < b};
            3'b100:  alu = a ^ b;
            3'b101:  alu = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'b110:  alu = a | b;
            default: alu = a & b;
        endcase
    endfunction

    assign instr     = imem_rdata;
    assign imem_addr = pc_r;
    assign opcode    = instr[6:0];
    assign rd        = instr[11:7];
    assign funct3    = instr[14:12];
    assign rs1       = instr[19:15];
    assign rs2       = instr[24:20];
    assign imm_i     = {{20{instr[31]}}, instr[31:20]};
    assign imm_s     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b     = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u     = {instr[31:12], 12'd0};
    assign imm_j     = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    cirno9_regfile u_regfile (
        .clk(clk), .rst_n(rst_n), .rs1_addr(rs1), .rs2_addr(rs2),
        .rs1_data(rs1_val), .rs2_data(rs2_val),
        .wr_en(rd_we), .wr_addr(rd), .wr_data(rd_wdata)
    );

    assign dmem_addr = rs1_val + ((opcode == 7'b0100011) ? imm_s : imm_i);

    always_comb begin
        case (dmem_addr[1:0])
            2'd0:    ld_byte = dmem_rdata[7:0];
            2'd1:    ld_byte = dmem_rdata[15:8];
            2'd2:    ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = dmem_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (funct3)
            3'b000:  taken = (rs1_val == rs2_val);
            3'b001:  taken = (rs1_val != rs2_val);
            3'b100:  taken = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  taken = (rs1_val <  rs2_val);
            3'b111:  taken = (rs1_val >= rs2_val);
            default: taken = 1'b0;
        endcase
    end

`ifdef CIRNO9_TRAP_EN
    logic [31:0] mtvec_r, mepc_r, mcause_r, csr_rdata, csr_src, csr_new;
    logic        is_system, csr_we, ecall;

    always_comb begin
        is_system = (opcode == 7'b1110011);
        ecall     = is_system && funct3 == 3'b000 && instr[31:20] == 12'h000;
        csr_src   = funct3[2] ? {27'd0, rs1} : rs1_val;
        case (instr[31:20])
            12'h305: csr_rdata = mtvec_r;
            12'h341: csr_rdata = mepc_r;
            12'h342: csr_rdata = mcause_r;
            default: csr_rdata = 32'd0;
        endcase
        case (funct3[1:0])
            2'b01:   csr_new = csr_src;
            2'b10:   csr_new = csr_rdata | csr_src;
            2'b11:   csr_new = csr_rdata & ~csr_src;
            default: csr_new = csr_rdata;
        endcase
        // Set/clear forms with a zero source field are pure reads.
        csr_we = is_system && funct3[1:0] != 2'b00 && (funct3[1:0] == 2'b01 || rs1 != 5'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtvec_r  <= '0;
            mepc_r   <= '0;
            mcause_r <= '0;
        end else if (ecall) begin
            mepc_r   <= pc_r;
            mcause_r <= 32'd11;
        end else if (csr_we) begin
            case (instr[31:20])
                12'h305: mtvec_r  <= csr_new;
                12'h341: mepc_r   <= csr_new;
                12'h342: mcause_r <= csr_new;
                default: ;
            endcase
        end
    end
`endif

    always_comb begin
        next_pc    = pc_r + 32'd4;
        rd_we      = 1'b0;
        rd_wdata   = 32'd0;
        dmem_we    = 4'b0000;
        dmem_wdata = rs2_val;
        case (opcode)
            7'b0110111: begin rd_we = 1'b1; rd_wdata = imm_u; end
            7'b0010111: begin rd_we = 1'b1; rd_wdata = pc_r + imm_u; end
            7'b1101111: begin rd_we = 1'b1; rd_wdata = pc_r + 32'd4; next_pc = pc_r + imm_j; end
            7'b1100111: begin
                rd_we    = 1'b1;
                rd_wdata = pc_r + 32'd4;
                next_pc  = (rs1_val + imm_i) & ~32'd1;
            end
            7'b1100011: if (taken) next_pc = pc_r + imm_b;
            7'b0000011: begin
                rd_we = 1'b1;
                case (funct3)
                    3'b000:  rd_wdata = {{24{ld_byte[7]}}, ld_byte};
                    3'b001:  rd_wdata = {{16{ld_half[15]}}, ld_half};
                    3'b100:  rd_wdata = {24'd0, ld_byte};
                    3'b101:  rd_wdata = {16'd0, ld_half};
                    default: rd_wdata = dmem_rdata;
                endcase
            end
            7'b0100011: begin
                case (funct3)
                    3'b000: begin dmem_we = 4'b0001 << dmem_addr[1:0]; dmem_wdata = {4{rs2_val[7:0]}}; end
                    3'b001: begin dmem_we = dmem_addr[1] ? 4'b1100 : 4'b0011; dmem_wdata = {2{rs2_val[15:0]}}; end
                    3'b010: dmem_we = 4'b1111;
                    default: ;
                endcase
            end
            7'b0010011: begin
                rd_we    = 1'b1;
                rd_wdata = alu(funct3, funct3 == 3'b101 && instr[30], rs1_val, imm_i);
            end
            7'b0110011: begin
                rd_we    = 1'b1;
                rd_wdata = alu(funct3, instr[30], rs1_val, rs2_val);
            end
            7'b1110011: begin
`ifdef CIRNO9_TRAP_EN
                if (funct3 == 3'b000) begin
                    if (ecall) next_pc = mtvec_r;
                    else if (instr[31:20] == 12'h302) next_pc = mepc_r;
                end else begin
                    rd_we    = 1'b1;
                    rd_wdata = csr_rdata;
                end
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_r <= RESET_PC;
        else        pc_r <= next_pc;
    end
endmodule

module cirno9_cpu_top #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          SRAM_AW  = 14
) (
    input logic clk,
    input logic rst_n
);
    logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_rdata, dmem_wdata;
    logic [3:0]  dmem_we, sram_we;
    logic        unused_addr_bits;

    cirno9_core #(.RESET_PC(RESET_PC)) u_cirno9_core (
        .clk(clk), .rst_n(rst_n),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .dmem_addr(dmem_addr), .dmem_rdata(dmem_rdata),
        .dmem_we(dmem_we), .dmem_wdata(dmem_wdata)
    );

    // A store presented while reset is asserted must never reach the array.
    assign sram_we = dmem_we & {4{rst_n}};
    assign unused_addr_bits = ^{imem_addr[31:SRAM_AW+2], imem_addr[1:0],
                                dmem_addr[31:SRAM_AW+2], dmem_addr[1:0]};

    cirno9_sram32 #(.AW(SRAM_AW)) u_sram32 (
        .clk(clk),
        .iaddr(imem_addr[SRAM_AW+1:2]), .idata(imem_rdata),
        .daddr(dmem_addr[SRAM_AW+1:2]), .drdata(dmem_rdata),
        .dwe(sram_we), .dwdata(dmem_wdata)
    );
endmodule

// File: tb/tb_cirno9_cpu_top.sv
// Directed bench for cirno9_cpu_top: straight-line vector table plus control-flow,
// mid-run reset and (with CIRNO9_TRAP_EN) trap sequences.
module tb_cirno9_cpu_top;
    logic clk;
    logic rst_n;

    cirno9_cpu_top dut (.clk(clk), .rst_n(rst_n));

    initial clk = 1'b0;
    always #20 clk = ~clk;

    localparam int K_REG = 0;
    localparam int K_MEM = 1;
    localparam int K_PC  = 2;

    typedef struct {
        logic [31:0] instr;
        int          kind;
        int          idx;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [28];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [31:0] rs1,
                                          input logic [31:0] f3, input logic [31:0] rd,
                                          input logic [6:0] op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
    endfunction
    function automatic logic [31:0] enc_r(input logic [31:0] f7, input logic [31:0] rs2,
                                          input logic [31:0] rs1, input logic [31:0] f3,
                                          input logic [31:0] rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction
    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [31:0] rs2,
                                          input logic [31:0] rs1, input logic [31:0] f3);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [31:0] rs2,
                                          input logic [31:0] rs1, input logic [31:0] f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_u(input logic [31:0] imm, input logic [31:0] rd,
                                          input logic [6:0] op);
        return {imm[19:0], rd[4:0], op};
    endfunction
    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [31:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end else begin
            $display("ok   %s: %08h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_reset();
        rst_n = 1'b0;
        #120;
        @(negedge clk);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 128; i++) dut.u_sram32.mem_r[i] = 32'd0;
    endtask

    logic [31:0] act;

    initial begin
        rst_n = 1'b0;

        vecs[0]  = '{enc_i(5, 0, 0, 1, 7'h13),            K_REG, 1,  32'h0000_0005};
        vecs[1]  = '{enc_i(-3, 0, 0, 2, 7'h13),           K_REG, 2,  32'hFFFF_FFFD};
        vecs[2]  = '{enc_r(0, 2, 1, 0, 3),                K_REG, 3,  32'h0000_0002};
        vecs[3]  = '{enc_r(32'h20, 1, 2, 0, 4),           K_REG, 4,  32'hFFFF_FFF8};
        vecs[4]  = '{enc_u(32'h80818, 5, 7'h37),          K_REG, 5,  32'h8081_8000};
        vecs[5]  = '{enc_i(32'h283, 5, 0, 5, 7'h13),      K_REG, 5,  32'h8081_8283};
        vecs[6]  = '{enc_u(32'h80000, 6, 7'h37),          K_REG, 6,  32'h8000_0000};
        vecs[7]  = '{enc_s(32'h100, 5, 6, 2),             K_MEM, 64, 32'h8081_8283};
        vecs[8]  = '{enc_i(32'h101, 6, 0, 7, 7'h03),      K_REG, 7,  32'hFFFF_FF82};
        vecs[9]  = '{enc_i(32'h101, 6, 4, 8, 7'h03),      K_REG, 8,  32'h0000_0082};
        vecs[10] = '{enc_i(32'h102, 6, 1, 9, 7'h03),      K_REG, 9,  32'hFFFF_8081};
        vecs[11] = '{enc_i(32'h102, 6, 5, 10, 7'h03),     K_REG, 10, 32'h0000_8081};
        vecs[12] = '{enc_i(32'h55, 0, 0, 11, 7'h13),      K_REG, 11, 32'h0000_0055};
        vecs[13] = '{enc_s(32'h103, 11, 6, 0),            K_MEM, 64, 32'h5581_8283};
        vecs[14] = '{enc_r(0, 1, 2, 2, 12),               K_REG, 12, 32'h0000_0001};
        vecs[15] = '{enc_r(0, 1, 2, 3, 12),               K_REG, 12, 32'h0000_0000};
        vecs[16] = '{enc_i(32'h402, 4, 5, 13, 7'h13),     K_REG, 13, 32'hFFFF_FFFE};
        vecs[17] = '{enc_i(28, 4, 5, 14, 7'h13),          K_REG, 14, 32'h0000_000F};
        vecs[18] = '{enc_i(3, 1, 1, 15, 7'h13),           K_REG, 15, 32'h0000_0028};
        vecs[19] = '{enc_i(-1, 1, 4, 16, 7'h13),          K_REG, 16, 32'hFFFF_FFFA};
        vecs[20] = '{enc_u(1, 17, 7'h17),                 K_REG, 17, 32'h8000_1050};
        vecs[21] = '{enc_i(1, 0, 0, 0, 7'h13),            K_REG, 0,  32'h0000_0000};
        vecs[22] = '{enc_i(32'h100, 6, 2, 18, 7'h03),     K_REG, 18, 32'h5581_8283};
        vecs[23] = '{enc_r(0, 15, 1, 6, 19),              K_REG, 19, 32'h0000_002D};
        vecs[24] = '{enc_r(0, 16, 4, 7, 20),              K_REG, 20, 32'hFFFF_FFF8};
        vecs[25] = '{enc_r(32'h20, 1, 4, 5, 21),          K_REG, 21, 32'hFFFF_FFFF};
        vecs[26] = '{enc_i(-1, 1, 3, 22, 7'h13),          K_REG, 22, 32'h0000_0001};
        vecs[27] = '{32'h0000_007F,                       K_PC,  0,  32'h8000_0070};

        // Straight-line program: one retirement per edge, checked after each.
        clear_mem();
        for (int i = 0; i < 28; i++) dut.u_sram32.mem_r[i] = vecs[i].instr;
        hold_reset();
        rst_n = 1'b1;
        #1;
        check("reset_pc", dut.u_cirno9_core.pc_r, 32'h8000_0000);
        check("reset_x3", dut.u_cirno9_core.u_regfile.rf_r[3], 32'd0);
        for (int i = 0; i < 28; i++) begin
            step();
            case (vecs[i].kind)
                K_REG:   act = dut.u_cirno9_core.u_regfile.rf_r[vecs[i].idx];
                K_MEM:   act = dut.u_sram32.mem_r[vecs[i].idx];
                default: act = dut.u_cirno9_core.pc_r;
            endcase
            check($sformatf("vec%0d", i), act, vecs[i].exp);
        end

        // Control flow: BNE taken, BEQ not taken, JAL +8, JALR with odd offset.
        hold_reset();
        clear_mem();
        dut.u_sram32.mem_r[0] = enc_i(1, 0, 0, 1, 7'h13);
        dut.u_sram32.mem_r[1] = enc_b(8, 0, 1, 1);
        dut.u_sram32.mem_r[2] = enc_i(99, 0, 0, 2, 7'h13);
        dut.u_sram32.mem_r[3] = enc_b(8, 0, 1, 0);
        dut.u_sram32.mem_r[4] = enc_j(8, 1);
        dut.u_sram32.mem_r[5] = enc_i(7, 0, 0, 3, 7'h13);
        dut.u_sram32.mem_r[6] = enc_i(1, 1, 0, 0, 7'h67);
        rst_n = 1'b1;
        begin
            logic [31:0] pc_seq [6];
            pc_seq[0] = 32'h8000_0004; pc_seq[1] = 32'h8000_000C; pc_seq[2] = 32'h8000_0010;
            pc_seq[3] = 32'h8000_0018; pc_seq[4] = 32'h8000_0014; pc_seq[5] = 32'h8000_0018;
            for (int i = 0; i < 6; i++) begin
                step();
                check($sformatf("cf_pc%0d", i), dut.u_cirno9_core.pc_r, pc_seq[i]);
                if (i == 3) check("cf_jal_x1", dut.u_cirno9_core.u_regfile.rf_r[1], 32'h8000_0014);
            end
        end
        check("cf_skip_x2", dut.u_cirno9_core.u_regfile.rf_r[2], 32'd0);
        check("cf_x3", dut.u_cirno9_core.u_regfile.rf_r[3], 32'd7);

        // Mid-cycle reset clears state at once; a store seen during reset is dropped.
        #5;
        rst_n = 1'b0;
        #1;
        check("mid_rst_pc", dut.u_cirno9_core.pc_r, 32'h8000_0000);
        check("mid_rst_x1", dut.u_cirno9_core.u_regfile.rf_r[1], 32'd0);
        dut.u_sram32.mem_r[64] = 32'hDEAD_BEEF;
        dut.u_sram32.mem_r[0]  = enc_s(32'h100, 0, 0, 2);
        step();
        step();
        check("rst_store_abort", dut.u_sram32.mem_r[64], 32'hDEAD_BEEF);

        // SYSTEM instructions: trap flow when enabled, plain NOPs otherwise.
        hold_reset();
        clear_mem();
        dut.u_sram32.mem_r[0]  = enc_u(32'h80000, 1, 7'h37);
        dut.u_sram32.mem_r[1]  = enc_i(32'h40, 1, 0, 1, 7'h13);
        dut.u_sram32.mem_r[2]  = enc_i(32'h305, 1, 1, 0, 7'h73);
        dut.u_sram32.mem_r[3]  = enc_i(0, 0, 0, 0, 7'h13);
        dut.u_sram32.mem_r[4]  = 32'h0000_0073;
        dut.u_sram32.mem_r[16] = enc_i(32'h341, 0, 2, 5, 7'h73);
        dut.u_sram32.mem_r[17] = enc_i(32'h342, 0, 2, 6, 7'h73);
        dut.u_sram32.mem_r[18] = 32'h3020_0073;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step();
`ifdef CIRNO9_TRAP_EN
        check("ecall_pc", dut.u_cirno9_core.pc_r, 32'h8000_0040);
        step();
        check("mepc_read", dut.u_cirno9_core.u_regfile.rf_r[5], 32'h8000_0010);
        step();
        check("mcause_read", dut.u_cirno9_core.u_regfile.rf_r[6], 32'd11);
        step();
        check("mret_pc", dut.u_cirno9_core.pc_r, 32'h8000_0010);
`else
        check("system_nop_pc", dut.u_cirno9_core.pc_r, 32'h8000_0014);
        check("system_nop_x1", dut.u_cirno9_core.u_regfile.rf_r[1], 32'h8000_0040);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
